// File: rtl/apb_script_master.sv
// APB master sequencer: runs a loaded script of WRITE / READ / POLL entries
// against an APB slave, with wait-state timeout, PSLVERR and poll-limit aborts.
module apb_script_master #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int DEPTH    = 32,
    parameter int TIMEOUT  = 255,
    parameter int POLL_MAX = 15,
    parameter int PW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_en,
    input  logic [PW-1:0] ld_idx,
    input  logic [1:0]    ld_op,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    input  logic [DW-1:0] ld_mask,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [1:0]    err_code,
    output logic [PW-1:0] pc,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic [AW-1:0] paddr,
    output logic          pwrite,
    output logic          psel,
    output logic          pen,
    output logic [DW-1:0] pwdata,
    input  logic [DW-1:0] prdata,
    input  logic          pready,
    input  logic          pslverr
);

    localparam logic [1:0] OP_END   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_POLL  = 2'b11;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int QW = $clog2(POLL_MAX + 1);

    typedef enum logic [2:0] {IDLE, FETCH, SETUP, ACCESS, DONE} state_t;

    typedef struct packed {
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] mask;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        cur;
    state_t        state;
    logic [TW-1:0] wait_cnt;
    logic [QW-1:0] poll_cnt;
    logic          abort_q;
    logic          poll_hit;
    logic          last_entry;

    // The script is only written while idle, so reading it at pc is stable for a whole run.
    assign cur        = mem[pc];
    assign poll_hit   = (prdata & cur.mask) == (cur.data & cur.mask);
    assign last_entry = abort_q || abort || (pc == PW'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (ld_en && !busy)
            mem[ld_idx] <= '{op: ld_op, addr: ld_addr, data: ld_data, mask: ld_mask};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            err_code <= 2'b00;
            pc       <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            paddr    <= '0;
            pwrite   <= 1'b0;
            psel     <= 1'b0;
            pen      <= 1'b0;
            pwdata   <= '0;
            wait_cnt <= '0;
            poll_cnt <= '0;
            abort_q  <= 1'b0;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
            if (busy && abort)
                abort_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FETCH;
                        pc       <= '0;
                        error    <= 1'b0;
                        err_code <= 2'b00;
                        busy     <= 1'b1;
                        abort_q  <= 1'b0;
                    end
                end
                FETCH: begin
                    if (cur.op == OP_END) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        paddr    <= cur.addr;
                        pwrite   <= (cur.op == OP_WRITE);
                        pwdata   <= (cur.op == OP_WRITE) ? cur.data : '0;
                        poll_cnt <= '0;
                        psel     <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    pen      <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (!pready) begin
                        if (wait_cnt == TW'(TIMEOUT - 1)) begin
                            error    <= 1'b1;
                            err_code <= 2'b10;
                            psel     <= 1'b0;
                            pen      <= 1'b0;
                            done     <= 1'b1;
                            state    <= DONE;
                        end else begin
                            wait_cnt <= wait_cnt + TW'(1);
                        end
                    end else if (pslverr) begin
                        error    <= 1'b1;
                        err_code <= 2'b01;
                        psel     <= 1'b0;
                        pen      <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        if (cur.op != OP_WRITE) begin
                            rd_data  <= prdata;
                            rd_valid <= 1'b1;
                        end
                        if (cur.op == OP_POLL && !poll_hit) begin
                            pen <= 1'b0;
                            if (poll_cnt == QW'(POLL_MAX - 1)) begin
                                error    <= 1'b1;
                                err_code <= 2'b11;
                                psel     <= 1'b0;
                                done     <= 1'b1;
                                state    <= DONE;
                            end else begin
                                // Retry keeps psel high and re-enters SETUP on the same address.
                                poll_cnt <= poll_cnt + QW'(1);
                                state    <= SETUP;
                            end
                        end else begin
                            psel <= 1'b0;
                            pen  <= 1'b0;
                            if (last_entry) begin
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                pc    <= pc + PW'(1);
                                state <= FETCH;
                            end
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/apb_script_master.md
# apb_script_master

Parametrised APB master sequencer that drives the SPI memory controller's APB register file (command, status, write-data, read-data) from a loadable script, not from hard-wired control codes. It executes WRITE, READ and POLL entries in order, with wait-state timeout and PSLVERR detection. It returns read data to the caller and sits between bench or system control logic and any APB slave on `pclk = clk`.

## Interface
- `AW`, 32: APB address width.
- `DW`, 32: APB data width.
- `DEPTH`, 32: script entries (power of two, ≥2); `PW = log2(DEPTH)`.
- `TIMEOUT`, 255: maximum ACCESS cycles with `pready`=0 before abort (≥1).
- `POLL_MAX`, 15: maximum POLL reads per entry (≥1).

- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `ld_en` in 1: write one script entry (ignored while `busy`).
- `ld_idx` in PW: entry index.
- `ld_op` in 2: 00 END, 01 WRITE, 10 READ, 11 POLL.
- `ld_addr` in AW, `ld_data` in DW, `ld_mask` in DW: entry fields.
- `start` in 1: run the script from entry 0 (ignored while `busy`).
- `abort` in 1: stop after the current transfer.
- `busy` out 1: a script is running.
- `done` out 1: one-cycle pulse at normal or aborted end.
- `error` out 1: sticky until the next accepted `start`.
- `err_code` out 2: 01 PSLVERR, 10 timeout, 11 poll exhausted.
- `pc` out PW: index of the current entry.
- `rd_data` out DW, `rd_valid` out 1: captured read data, with a one-cycle valid pulse.
- `paddr` out AW, `pwrite` out 1, `psel` out 1, `pen` out 1, `pwdata` out DW: APB master outputs.
- `prdata` in DW, `pready` in 1, `pslverr` in 1: APB slave responses.

## Operation
- Script RAM: DEPTH × (2+AW+2·DW) registers, synchronous write via `ld_*`. Contents are undefined after reset; only the control registers are reset.
- Reset value of every output is 0.
- States:
  - IDLE
  - FETCH: read entry at `pc`.
  - SETUP: `psel`=1, `pen`=0.
  - ACCESS: `psel`=1, `pen`=1.
  - DONE: `done`=1.
- Transitions:
  - IDLE + `start` → FETCH, with `pc`←0, `error`←0, `err_code`←0, `busy`←1.
  - FETCH: op END → DONE. Otherwise load `paddr`/`pwrite`/`pwdata` from the entry, clear the poll counter, → SETUP.
  - SETUP → ACCESS, unconditionally.
  - ACCESS with `pready`=0: stay and count wait cycles. When the count reaches `TIMEOUT`, set `error`, `err_code`=10, → DONE, deasserting `psel`/`pen`.
  - ACCESS with `pready`=1 and `pslverr`=1: set `error`, `err_code`=01, → DONE.
  - ACCESS with `pready`=1 on a WRITE: → next entry.
  - ACCESS with `pready`=1 on a READ: `rd_data`←`prdata`, `rd_valid` pulses, → next entry.
  - ACCESS with `pready`=1 on a POLL: `rd_data`←`prdata`, `rd_valid` pulses. If (`prdata` & mask) == (data & mask), → next entry. Else increment the poll counter. If the count reaches `POLL_MAX`, set `error`, `err_code`=11, → DONE. Otherwise → SETUP with the same address.
  - Next entry: if `abort` has been latched or `pc`==DEPTH-1, → DONE. Else `pc`+1 → FETCH.
  - DONE → IDLE, `busy`←0.
- `abort` is latched whenever it is seen while `busy` and cleared on `start`. A transfer in progress always completes or times out; `psel` is never dropped mid-ACCESS except on timeout.
- `pwrite`, `paddr` and `pwdata` hold stable from SETUP through the last ACCESS cycle. `pwdata` is 0 for READ and POLL.
- `pc` never wraps: reaching DEPTH-1 without an END entry ends the run normally.
- `ld_en` and `start` together while idle: the load is performed and the start is accepted. The run uses the new entry.
- `rst` asserted mid-run: all outputs clear immediately and asynchronously. The run does not resume.

## Timing
- `start` sampled at edge t: FETCH in cycle t+1, SETUP t+2, ACCESS t+3.
- Zero-wait transfer: 3 cycles per entry (FETCH, SETUP, ACCESS). Each wait state adds 1 cycle.
- POLL retry: 2 cycles per extra read (SETUP, ACCESS).
- `rd_valid` and `rd_data` update in the cycle after the completing ACCESS edge.
- `done` is asserted 1 cycle after the last completing edge. `busy` falls 1 cycle after that.
- A one-entry END script asserts `done` 2 cycles after `start`.

## Test plan
- Script [WRITE A0 D=0x188, WRITE A2 D=0x3, END] against a zero-wait slave → two write transfers of 3 cycles each with correct `paddr`/`pwdata`. `done` pulses once, `error`=0.
- READ A3 with `prdata`=0xDEADBEEF and 2 wait states → ACCESS lasts 3 cycles. `rd_valid` pulses once with `rd_data`=0xDEADBEEF.
- POLL A1 mask=0x1 data=0x0, with the slave returning 0x1 twice then 0x0 → 3 reads, the bench sees 3 `rd_valid` pulses, then the script advances.
- POLL that never matches, `POLL_MAX`=4 → exactly 4 reads, `error`=1, `err_code`=11.
- `pready` held low with `TIMEOUT`=8 → `psel`/`pen` drop after 8 ACCESS cycles, `err_code`=10. `pslverr` on the second entry → `err_code`=01, `pc`=1.
- `abort` during entry 1 of a 5-entry script → entry 1 completes and `done` follows with `pc`=1. `rst` pulled low mid-ACCESS → all outputs 0 with no clock edge.
